// File: rtl/nmea_rmc_parser.sv
// Streaming NMEA RMC sentence parser: latches UTC time, date and fix status from
// checksummed sentences and mirrors each field's text into a row of a text RAM.
module nmea_rmc_parser #(
    parameter int MAX_LEN  = 82,
    parameter int ROW_BITS = 5
) (
    input  logic        PixelClk,
    input  logic        nRST,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [23:0] time_bcd,
    output logic [23:0] date_bcd,
    output logic        fix_valid,
    output logic        time_update,
    output logic        cksum_err,
    output logic        wr_en,
    output logic [9:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic [2:0]  dbg_state
);
    localparam int RB = 10 - ROW_BITS;
    localparam int CW = $clog2(MAX_LEN + 2);

    // rx_valid/rx_data form a one-cycle strobe with no back-pressure: every byte
    // presented with rx_valid high is consumed in that cycle.
    typedef enum logic [2:0] {IDLE, HEADER, FIELDS, CK_HI, CK_LO} state_t;

    state_t          state;
    logic [1:0]      rst_sync;
    logic            rst_n;
    logic [7:0]      xor_acc;
    logic [3:0]      ck_hi;
    logic [CW-1:0]   byte_cnt;
    logic [3:0]      field_idx;
    logic [2:0]      digit_idx;
    logic [RB-1:0]   row;
    logic [ROW_BITS:0] col;
    logic [23:0]     sh_time;
    logic [23:0]     sh_date;
    logic            sh_status;
    logic            bad;
    logic            time_ok;
    logic            date_ok;

    logic            is_eol;
    logic            is_digit;
    logic            hex_ok;
    logic [3:0]      hex_val;
    logic [7:0]      hdr_exp;
    logic [3:0]      dig;
    logic [4:0]      dig_base;

    // Assert asynchronously, release only after two PixelClk edges.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) rst_sync <= 2'b00;
        else       rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    always_comb begin
        is_eol   = (rx_data == 8'h0D) || (rx_data == 8'h0A);
        is_digit = (rx_data >= "0") && (rx_data <= "9");
        hex_ok   = 1'b0;
        hex_val  = 4'h0;
        if (is_digit) begin
            hex_ok  = 1'b1;
            hex_val = rx_data[3:0];
        end else if (((rx_data >= "A") && (rx_data <= "F")) ||
                     ((rx_data >= "a") && (rx_data <= "f"))) begin
            hex_ok  = 1'b1;
            hex_val = rx_data[3:0] + 4'd9;
        end
        // Talker ID bytes match anything; only the sentence type is checked.
        case (byte_cnt)
            CW'(3):  hdr_exp = "R";
            CW'(4):  hdr_exp = "M";
            CW'(5):  hdr_exp = "C";
            default: hdr_exp = rx_data;
        endcase
        dig      = rx_data[3:0];
        dig_base = 5'd20 - {digit_idx, 2'b00};
    end

    assign dbg_state = state;

    always_ff @(posedge PixelClk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            time_bcd    <= '0;
            date_bcd    <= '0;
            fix_valid   <= 1'b0;
            time_update <= 1'b0;
            cksum_err   <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            xor_acc     <= '0;
            ck_hi       <= '0;
            byte_cnt    <= '0;
            field_idx   <= '0;
            digit_idx   <= '0;
            row         <= '0;
            col         <= '0;
            sh_time     <= '0;
            sh_date     <= '0;
            sh_status   <= 1'b0;
            bad         <= 1'b0;
            time_ok     <= 1'b0;
            date_ok     <= 1'b0;
        end else begin
            wr_en       <= 1'b0;
            time_update <= 1'b0;
            cksum_err   <= 1'b0;
            if (rx_valid) begin
                if (rx_data == "$") begin
                    state     <= HEADER;
                    xor_acc   <= '0;
                    byte_cnt  <= CW'(1);
                    bad       <= 1'b0;
                    time_ok   <= 1'b0;
                    date_ok   <= 1'b0;
                    sh_status <= 1'b0;
                end else if (state != IDLE) begin
                    if (is_eol) begin
                        if (state == FIELDS) state <= IDLE;
                    end else if (byte_cnt >= CW'(MAX_LEN)) begin
                        state <= IDLE;
                    end else begin
                        byte_cnt <= byte_cnt + 1'b1;
                        case (state)
                            HEADER: begin
                                xor_acc <= xor_acc ^ rx_data;
                                if (rx_data != hdr_exp) begin
                                    state <= IDLE;
                                end else if (byte_cnt == CW'(5)) begin
                                    state     <= FIELDS;
                                    field_idx <= '0;
                                    digit_idx <= '0;
                                    row       <= '0;
                                    col       <= '0;
                                    wr_addr   <= '0;
                                end
                            end
                            FIELDS: begin
                                if (rx_data == "*") begin
                                    state <= CK_HI;
                                end else begin
                                    xor_acc <= xor_acc ^ rx_data;
                                    if (rx_data == ",") begin
                                        if (field_idx != 4'hF) field_idx <= field_idx + 1'b1;
                                        digit_idx <= '0;
                                        row       <= row + 1'b1;
                                        col       <= '0;
                                        wr_addr   <= {row + 1'b1, {ROW_BITS{1'b0}}};
                                    end else begin
                                        // col's extra top bit marks a full row.
                                        if (!col[ROW_BITS]) begin
                                            wr_en   <= 1'b1;
                                            wr_data <= rx_data;
                                            wr_addr <= {row, col[ROW_BITS-1:0]};
                                            col     <= col + 1'b1;
                                        end
                                        if (digit_idx != 3'd7) digit_idx <= digit_idx + 1'b1;
                                        if (digit_idx < 3'd6) begin
                                            if (field_idx == 4'd1) begin
                                                sh_time[dig_base +: 4] <= dig;
                                                if (!is_digit) bad <= 1'b1;
                                                if (digit_idx == 3'd5) time_ok <= 1'b1;
                                            end
                                            if (field_idx == 4'd9) begin
                                                sh_date[dig_base +: 4] <= dig;
                                                if (!is_digit) bad <= 1'b1;
                                                if (digit_idx == 3'd5) date_ok <= 1'b1;
                                            end
                                        end
                                        if (field_idx == 4'd2) sh_status <= (rx_data == "A");
                                    end
                                end
                            end
                            CK_HI: begin
                                if (hex_ok) begin
                                    ck_hi <= hex_val;
                                    state <= CK_LO;
                                end else begin
                                    state <= IDLE;
                                end
                            end
                            CK_LO: begin
                                state <= IDLE;
                                if (hex_ok) begin
                                    if ({ck_hi, hex_val} != xor_acc) begin
                                        cksum_err <= 1'b1;
                                    end else if (!bad && time_ok && date_ok) begin
                                        time_bcd    <= sh_time;
                                        date_bcd    <= sh_date;
                                        fix_valid   <= sh_status;
                                        time_update <= 1'b1;
                                    end
                                end
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_nmea_rmc_parser.sv
// Bench for nmea_rmc_parser: directed and random sentences checked against a
// string-level reference model and a text-RAM write scoreboard.
module tb_nmea_rmc_parser;
    localparam int MAX_LEN = 82;

    logic        PixelClk = 1'b0;
    logic        nRST = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [23:0] time_bcd, date_bcd;
    logic        fix_valid, time_update, cksum_err, wr_en;
    logic [9:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad = 0;
    int upd_cnt = 0;
    int err_cnt = 0;
    logic [17:0] exp_q[$];
    logic [17:0] exp_w;
    logic [23:0] exp_time = '0;
    logic [23:0] exp_date = '0;
    logic        exp_fix = 1'b0;

    nmea_rmc_parser #(.MAX_LEN(MAX_LEN), .ROW_BITS(5)) dut (
        .PixelClk(PixelClk), .nRST(nRST), .rx_data(rx_data), .rx_valid(rx_valid),
        .time_bcd(time_bcd), .date_bcd(date_bcd), .fix_valid(fix_valid),
        .time_update(time_update), .cksum_err(cksum_err), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .dbg_state(dbg_state)
    );

    always #5 PixelClk = ~PixelClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Pulse counting and write scoreboard.
    always @(negedge PixelClk) begin
        if (nRST) begin
            if (time_update) upd_cnt++;
            if (cksum_err) err_cnt++;
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("wr_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("wr_addr", 32'(wr_addr), 32'(exp_w[17:8]));
                    chk("wr_data", 32'(wr_data), 32'(exp_w[7:0]));
                end
            end
        end
    end

    function automatic bit is_rmc(input string s);
        return (s.len() >= 6) && (s.substr(3, 5) == "RMC");
    endfunction

    // Expected text-RAM writes: one row per field, columns saturate at 31.
    function automatic void model_writes(input string s);
        int field = 0;
        int col = 0;
        if (!is_rmc(s)) return;
        for (int i = 6; i < s.len(); i++) begin
            byte c = s[i];
            if (i + 1 > MAX_LEN) break;
            if (c == "*" || c == 8'h0D || c == 8'h0A || c == "$") break;
            if (c == ",") begin
                field++;
                col = 0;
            end else if (col < 32) begin
                exp_q.push_back({10'(((field % 32) * 32) + col), c});
                col++;
            end
        end
    endfunction

    function automatic string get_field(input string s, input int k, input int stop);
        int f = 0;
        string r = "";
        for (int i = 1; i < stop; i++) begin
            if (s[i] == ",") f++;
            else if (f == k) r = $sformatf("%s%c", r, s[i]);
        end
        return r;
    endfunction

    function automatic bit digits6(input string f);
        if (f.len() < 6) return 1'b0;
        for (int i = 0; i < 6; i++)
            if (f[i] < "0" || f[i] > "9") return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [23:0] bcd6(input string f);
        logic [23:0] v = '0;
        for (int i = 0; i < 6; i++) v = {v[19:0], 4'(f[i] - "0")};
        return v;
    endfunction

    function automatic int hexv(input byte c);
        if (c >= "0" && c <= "9") return c - "0";
        if (c >= "A" && c <= "F") return c - "A" + 10;
        if (c >= "a" && c <= "f") return c - "a" + 10;
        return -1;
    endfunction

    task automatic model_sentence(input string s, output int e_upd, output int e_err);
        int star = -1;
        int h, l;
        byte x = 0;
        string f1, f2, f9;
        e_upd = 0;
        e_err = 0;
        for (int i = 0; i < s.len(); i++)
            if (s[i] == "*") begin star = i; break; end
        if (star < 0 || s.len() < star + 3 || !is_rmc(s) || star + 3 > MAX_LEN) return;
        for (int i = 1; i < star; i++) x = x ^ s[i];
        h = hexv(s[star + 1]);
        l = hexv(s[star + 2]);
        if (h < 0 || l < 0) return;
        if (h * 16 + l != int'(x)) begin
            e_err = 1;
            return;
        end
        f1 = get_field(s, 1, star);
        f2 = get_field(s, 2, star);
        f9 = get_field(s, 9, star);
        if (digits6(f1) && digits6(f9)) begin
            e_upd = 1;
            exp_time = bcd6(f1);
            exp_date = bcd6(f9);
            exp_fix = (f2.len() > 0) && (f2[f2.len() - 1] == "A");
        end
    endtask

    function automatic string mk(input string body, input bit lower);
        byte x = 0;
        for (int i = 0; i < body.len(); i++) x = x ^ body[i];
        return {"$", body, "*", lower ? $sformatf("%02x", x) : $sformatf("%02X", x)};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge PixelClk);
        rx_data = b;
        rx_valid = 1'b1;
        @(negedge PixelClk);
        rx_valid = 1'b0;
        rx_data = 8'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge PixelClk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic run(input string tag, input string s);
        int e_upd, e_err;
        model_writes(s);
        model_sentence(s, e_upd, e_err);
        upd_cnt = 0;
        err_cnt = 0;
        send_str(s);
        repeat (3) @(negedge PixelClk);
        chk({tag, ":time_update"}, 32'(upd_cnt), 32'(e_upd));
        chk({tag, ":cksum_err"}, 32'(err_cnt), 32'(e_err));
        chk({tag, ":time_bcd"}, 32'(time_bcd), 32'(exp_time));
        chk({tag, ":date_bcd"}, 32'(date_bcd), 32'(exp_date));
        chk({tag, ":fix_valid"}, 32'(fix_valid), 32'(exp_fix));
        chk({tag, ":writes_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ":time_bcd"}, 32'(time_bcd), 32'd0);
        chk({tag, ":date_bcd"}, 32'(date_bcd), 32'd0);
        chk({tag, ":fix_valid"}, 32'(fix_valid), 32'd0);
        chk({tag, ":pulses"}, 32'({time_update, cksum_err, wr_en}), 32'd0);
        chk({tag, ":wr_addr"}, 32'(wr_addr), 32'd0);
        chk({tag, ":wr_data"}, 32'(wr_data), 32'd0);
        chk({tag, ":state"}, 32'(dbg_state), 32'd0);
    endtask

    localparam string EX_BODY = "GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W";

    initial begin
        string s;
        // Reset phase.
        #12;
        check_reset("reset");
        @(negedge PixelClk);
        nRST = 1'b1;
        repeat (4) @(negedge PixelClk);

        // Reference sentence, then its corrupted-checksum twin.
        run("example", {"$", EX_BODY, "*6A"});
        chk("example:time_const", 32'(time_bcd), 32'h123519);
        chk("example:date_const", 32'(date_bcd), 32'h230394);
        chk("example:fix_const", 32'(fix_valid), 32'd1);
        run("bad_cksum", {"$", EX_BODY, "*6B"});
        run("status_v", mk("GPRMC,081530,V,4807.038,N,01131.000,E,022.4,084.4,150624,003.1,W", 1'b0));
        chk("status_v:fix_const", 32'(fix_valid), 32'd0);

        // Aborted sentence followed by a valid one from another talker.
        run("abort", "$GPRMC,12");
        run("gn", mk("GNRMC,235959.50,A,,,,,,,311299,,", 1'b1));
        run("gga", mk("GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9", 1'b0));
        run("bad_hex", {"$", EX_BODY, "*6G"});

        // Over-long field then CR abort.
        s = "$GPRMC,1,A,";
        for (int i = 0; i < 40; i++) s = $sformatf("%s%c", s, 8'h41 + 8'(i % 26));
        s = $sformatf("%s%c", s, 8'h0D);
        run("long_field", s);

        // Reset in the middle of field 1.
        run("pre_rst", "$GPRMC,1235");
        @(negedge PixelClk);
        nRST = 1'b0;
        #2;
        check_reset("mid_rst");
        exp_time = '0;
        exp_date = '0;
        exp_fix = 1'b0;
        @(negedge PixelClk);
        nRST = 1'b1;
        repeat (4) @(negedge PixelClk);
        run("post_rst", mk("GPRMC,010203,A,,,,,,,040506,,", 1'b0));

        // Random sentences.
        for (int n = 0; n < 16; n++) begin
            string tstr, dstr, st, body;
            int kind;
            tstr = $sformatf("%02d%02d%02d.%02d", $urandom_range(0, 23), $urandom_range(0, 59),
                             $urandom_range(0, 59), $urandom_range(0, 99));
            dstr = $sformatf("%02d%02d%02d", $urandom_range(1, 31), $urandom_range(1, 12),
                             $urandom_range(0, 99));
            st = ($urandom_range(0, 1) == 1) ? "A" : "V";
            kind = $urandom_range(0, 7);
            if (kind == 0) tstr = {tstr.substr(0, 1), "x", tstr.substr(3, tstr.len() - 1)};
            if (kind == 1) dstr = dstr.substr(0, 4);
            body = $sformatf("GNRMC,%s,%s,4807.038,N,01131.000,E,022.4,084.4,%s,,", tstr, st, dstr);
            s = mk(body, 1'($urandom_range(0, 1)));
            if (kind == 2)
                s = $sformatf("%s%c", s.substr(0, s.len() - 2),
                              (s[s.len() - 1] == "0") ? 8'h31 : 8'h30);
            run($sformatf("rnd%0d", n), s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nmea_rmc_parser.md
NMEA_RMC_PARSER -- requirements
Module: nmea_rmc_parser

Interface
REQ-001 Parameter MAX_LEN, default 82; maximum sentence length in bytes, '$' through second checksum digit.
REQ-002 Parameter ROW_BITS, default 5; log2 of text-RAM row length in bytes.
REQ-003 PixelClk  input  1  system clock; all logic on rising edge.
REQ-004 nRST  input  1  reset, asynchronous assert, active-low.
REQ-005 rx_data  input  8  received UART byte.
REQ-006 rx_valid  input  1  one-cycle strobe; rx_data valid this cycle.
REQ-007 time_bcd  output  24  UTC hhmmss, 4-bit BCD digits, MSB = tens of hours.
REQ-008 date_bcd  output  24  ddmmyy, 4-bit BCD digits, MSB = tens of day.
REQ-009 fix_valid  output  1  last committed sentence had status 'A'.
REQ-010 time_update  output  1  one-cycle pulse when time_bcd/date_bcd/fix_valid are committed.
REQ-011 cksum_err  output  1  one-cycle pulse on a checksum mismatch.
REQ-012 wr_en  output  1  text-RAM write strobe.
REQ-013 wr_addr  output  10  text-RAM address; {row, column}, column = low ROW_BITS bits.
REQ-014 wr_data  output  8  text-RAM write byte.

Function
REQ-015 States: IDLE, HEADER, FIELDS, CK_HI, CK_LO; one state transition at most per rx_valid byte.
REQ-016 IDLE: '$' -> HEADER; running XOR cleared; byte counter set to 1; all other bytes ignored.
REQ-017 HEADER: 5 bytes collected; bytes 3..5 = "RMC" (talker ID ignored) -> FIELDS; otherwise -> IDLE.
REQ-018 HEADER match: field index = 0, digit index = 0, wr_addr = 0.
REQ-019 Running XOR covers every byte after '$' and before '*'.
REQ-020 FIELDS: ',' increments field index, zeroes digit index, sets wr_addr = (row+1, column 0).
REQ-021 FIELDS: '*' -> CK_HI.
REQ-022 FIELDS, any other byte: wr_en pulses one cycle after the rx_valid, with wr_data = byte and wr_addr = current address; address column then increments.
REQ-023 Column saturates at 2^ROW_BITS-1; further bytes of the field are not written.
REQ-024 Row wraps modulo 2^(10-ROW_BITS).
REQ-025 Field 1, digits 0..5 -> shadow time digits; field 9, digits 0..5 -> shadow date digits; digit value = byte - "0", truncated to 4 bits.
REQ-026 Field 1 bytes past digit 5 (e.g. ".00") are written to RAM only.
REQ-027 Field 2 byte -> shadow status; status = 'A' -> valid, any other value -> invalid.
REQ-028 Any non-digit in field 1 digits 0..5 or field 9 digits 0..5 sets a sentence-bad flag.
REQ-029 CK_HI / CK_LO accept hex 0-9, A-F, a-f; a non-hex byte -> IDLE, no pulse.
REQ-030 After CK_LO: received checksum == running XOR, flag clear, and field 1 and field 9 both have 6 digits -> commit.
REQ-031 Commit: shadow copied to time_bcd, date_bcd and fix_valid in one cycle; time_update = 1 for the cycle after the CK_LO byte.
REQ-032 Checksum mismatch: cksum_err = 1 for the cycle after the CK_LO byte; outputs unchanged.
REQ-033 Failure for any other reason: no pulse; outputs unchanged.
REQ-034 After CK_LO the FSM always returns to IDLE.
REQ-035 '$' in any non-IDLE state aborts the sentence; the FSM restarts HEADER with that '$'.
REQ-036 Byte counter exceeding MAX_LEN -> IDLE; no commit, no pulse.
REQ-037 CR, LF and bytes while rx_valid = 0 have no effect outside FIELDS.
REQ-038 CR or LF in FIELDS aborts the sentence -> IDLE.
REQ-039 Committed outputs change only on commit.
REQ-040 Partial sentences never alter time_bcd, date_bcd or fix_valid.

Reset
REQ-041 nRST low: state = IDLE, immediately and asynchronously.
REQ-042 nRST low: time_bcd, date_bcd = 0; fix_valid, time_update, cksum_err, wr_en = 0; wr_addr, wr_data = 0.
REQ-043 nRST low: shadow registers, XOR, counters and sentence-bad flag cleared.
REQ-044 Reset mid-sentence discards the sentence; the first byte accepted after release is treated as in IDLE.
REQ-045 Reset release is synchronised to PixelClk within the block.

Verification
REQ-046 "$GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W*6A" -> one time_update; time_bcd = 0x123519, date_bcd = 0x230394, fix_valid = 1.
REQ-047 Same sentence with checksum "*6B" -> one cksum_err; no time_update; outputs keep their prior values.
REQ-048 Status 'V', correct checksum -> time_update; fix_valid = 0; time/date updated.
REQ-049 "$GPRMC,12" then "$GNRMC..." (valid sentence) -> first discarded; second commits.
REQ-050 Byte "1" of field 1 -> wr_en at wr_addr = 0x020, wr_data = 0x31.
REQ-051 Field 9 first byte -> wr_addr = 0x120.
REQ-052 Over-long field -> column saturates at 31.
REQ-053 nRST pulsed mid-field, then a full valid sentence -> outputs zero after reset; single correct commit afterwards.
